// File: rtl/md_pkg.sv
// Shared types for the multiply/divide scheduler: operation codes, FSM states
// and the busy-counter width.
package md_pkg;

    localparam int MD_CNT_W = 4;

    typedef enum logic [3:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MTHI    = 4'd5,
        MTLO    = 4'd6,
        MADD    = 4'd7,
        MADDU   = 4'd8,
        MSUB    = 4'd9,
        MSUBU   = 4'd10
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit product and quotient/remainder for the operands latched
// by md_sched; signedness follows the operation code.
module md_arith
    import md_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] prod,
    output logic [31:0] quot,
    output logic [31:0] rem,
    output logic        div_zero
);

    logic        is_signed;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;

    always_comb begin
        is_signed = (op == MULT) || (op == DIV) || (op == MADD) || (op == MSUB);
        ext_a     = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        ext_b     = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        // Low 64 bits of the 64x64 product are exact for both signednesses.
        prod      = ext_a * ext_b;

        // Signed divide via magnitudes: quotient truncates toward zero and the
        // remainder takes the dividend's sign; 0x80000000 / -1 falls out as
        // 0x80000000 rem 0 without a special case.
        neg_a     = is_signed & a[31];
        neg_b     = is_signed & b[31];
        mag_a     = neg_a ? (32'd0 - a) : a;
        mag_b     = neg_b ? (32'd0 - b) : b;
        div_zero  = (b == 32'd0);
        uq        = div_zero ? 32'd0 : (mag_a / mag_b);
        ur        = div_zero ? 32'd0 : (mag_a % mag_b);
        quot      = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        rem       = neg_a ? (32'd0 - ur) : ur;
    end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler owning architectural HI/LO and the MD busy flag.
// Define MD_SCHED_MADD_EN to accept MADD/MADDU/MSUB/MSUBU.
module md_sched
    import md_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  md_op_t      op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t             state_reg;
    logic [MD_CNT_W-1:0]   cnt_reg;
    md_op_t                op_reg;
    logic [31:0]           a_reg;
    logic [31:0]           b_reg;
    logic [31:0]           hi_reg;
    logic [31:0]           lo_reg;
    logic                  busy_reg;

    logic [63:0]           prod;
    logic [31:0]           quot;
    logic [31:0]           rem;
    logic                  div_zero;

    md_arith u_arith (
        .op       (op_reg),
        .a        (a_reg),
        .b        (b_reg),
        .prod     (prod),
        .quot     (quot),
        .rem      (rem),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= MD_NONE;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // busy is always low here, so issue only needs start and !flush.
                    if (start && !flush) begin
                        case (op)
                            MULT, MULTU
`ifdef MD_SCHED_MADD_EN
                            , MADD, MADDU, MSUB, MSUBU
`endif
                            : begin
                                state_reg <= ST_MUL;
                                cnt_reg   <= MD_CNT_W'(MUL_CYCLES);
                                busy_reg  <= 1'b1;
                                op_reg    <= op;
                                a_reg     <= rs_val;
                                b_reg     <= rt_val;
                            end
                            DIV, DIVU: begin
                                state_reg <= ST_DIV;
                                cnt_reg   <= MD_CNT_W'(DIV_CYCLES);
                                busy_reg  <= 1'b1;
                                op_reg    <= op;
                                a_reg     <= rs_val;
                                b_reg     <= rt_val;
                            end
                            MTHI:    hi_reg <= rs_val;
                            MTLO:    lo_reg <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt_reg == MD_CNT_W'(1)) begin
                        case (op_reg)
`ifdef MD_SCHED_MADD_EN
                            MADD, MADDU: {hi_reg, lo_reg} <= {hi_reg, lo_reg} + prod;
                            MSUB, MSUBU: {hi_reg, lo_reg} <= {hi_reg, lo_reg} - prod;
`endif
                            default:     {hi_reg, lo_reg} <= prod;
                        endcase
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - MD_CNT_W'(1);
                    end
                end
                ST_DIV: begin
                    if (cnt_reg == MD_CNT_W'(1)) begin
                        // Divide by zero runs the full latency but leaves HI/LO alone.
                        if (!div_zero) begin
                            hi_reg <= rem;
                            lo_reg <= quot;
                        end
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg - MD_CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched; expected values are hand-computed.
module tb_md_sched;
    import md_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    md_op_t      op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int passed = 0;
    int total  = 0;
    int n;

    md_sched #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .flush   (flush),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic issue(input md_op_t o, input logic [31:0] a, input logic [31:0] b,
                         input logic f);
        $display("txn op=%s rs=%08h rt=%08h flush=%0b", o.name(), a, b, f);
        op = o; rs_val = a; rt_val = b; flush = f; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0; op = MD_NONE;
    endtask

    // Counts edges until busy falls, starting just after the issue edge.
    task automatic wait_done(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = MD_NONE;
        rs_val = '0; rt_val = '0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // MULT -3 * 5 = -15
        issue(MULT, 32'hFFFF_FFFD, 32'd5, 1'b0);
        wait_done(n);
        chk("mult_cycles", 32'(n), 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);

        // MULTU 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(n);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        // DIV -7 / 2 -> q=-3, r=-1
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done(n);
        chk("div_cycles", 32'(n), 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        issue(DIVU, 32'd7, 32'd2, 1'b0);
        wait_done(n);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        // MTHI/MTLO visible right after the issue edge, no busy.
        issue(MTHI, 32'h1234, 32'd0, 1'b0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h1234);
        issue(MTLO, 32'h5678, 32'd0, 1'b0);
        chk("mtlo_lo", lo, 32'h5678);

        // Divide by zero: full latency, HI/LO untouched.
        issue(DIVU, 32'd99, 32'd0, 1'b0);
        wait_done(n);
        chk("div0_cycles", 32'(n), 32'd10);
        chk("div0_hi", hi, 32'h1234);
        chk("div0_lo", lo, 32'h5678);

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done(n);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'd0);

        // Start during busy is ignored; operand changes after issue don't matter.
        issue(MULT, 32'd3, 32'd4, 1'b0);
        issue(DIV, 32'd100, 32'd7, 1'b0);
        rs_val = 32'd55;
        rt_val = 32'd66;
        wait_done(n);
        chk("busy_ign_cycles", 32'(n + 1), 32'd5);
        chk("busy_ign_hi", hi, 32'd0);
        chk("busy_ign_lo", lo, 32'd12);

        // Flushed MTLO is dropped.
        issue(MTLO, 32'hAAAA, 32'd0, 1'b1);
        chk("flush_mtlo_lo", lo, 32'd12);
        chk("flush_mtlo_busy", {31'd0, busy}, 32'd0);

        // Flush after issue does not cancel the in-flight multiply.
        issue(MULT, 32'd2, 32'd3, 1'b0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_done(n);
        chk("late_flush_lo", lo, 32'd6);

        // Async reset in the middle of a divide aborts it.
        issue(DIV, 32'd100, 32'd3, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        $display("txn reset_n=0 mid DIV");
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("midrst_nocommit_lo", lo, 32'd0);
        chk("midrst_nocommit_busy", {31'd0, busy}, 32'd0);

        // MADD 2*3 on {0,1}: accumulated only when enabled.
        issue(MTHI, 32'd0, 32'd0, 1'b0);
        issue(MTLO, 32'd1, 32'd0, 1'b0);
        issue(MADD, 32'd2, 32'd3, 1'b0);
`ifdef MD_SCHED_MADD_EN
        wait_done(n);
        chk("madd_cycles", 32'(n), 32'd5);
        chk("madd_lo", lo, 32'd7);
        chk("madd_hi", hi, 32'd0);
`else
        chk("madd_off_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("madd_off_lo", lo, 32'd1);
        chk("madd_off_hi", hi, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
